seq_ctrl: RTL and testbench
===========================

# seq_ctrl

Multi-cycle sequencer for the SEQ Y86-64 core. It owns the program counter and steps each instruction through the fetch, decode, execute, memory, writeback and PC-update phases with one-hot stage enables. It waits on a ready/request handshake with data memory and converts fetch and memory faults into the architectural status code. It sits between the combinational fetch unit (driven by `pc_o`) and the stage register enables of the datapath.

## Interface
Parameters:
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `CNT_W`, 32: width of the cycle and retired-instruction counters.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: level; leaves IDLE when high.
- `icode_i` in 4: icode from the fetch unit for the current `pc_o`.
- `instr_valid_i` in 1: fetch reports a valid icode.
- `imem_error_i` in 1: fetch reports an out-of-range PC.
- `mem_ready_i` in 1: data memory has completed the request.
- `dmem_error_i` in 1: data memory fault; qualified by `mem_ready_i`.
- `new_pc_i` in 64: next PC computed by the PC-select logic.
- `pc_o` out 64: current PC, fed to fetch.
- `f_en_o`, `d_en_o`, `e_en_o`, `m_en_o`, `w_en_o`, `pc_en_o` out 1 each: one-hot stage enables.
- `mem_req_o` out 1: data memory request.
- `stat_o` out 3: status. 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- `running_o` out 1: high outside IDLE and STOP.
- `cycle_cnt_o` out CNT_W: count of running cycles.
- `instr_cnt_o` out CNT_W: count of retired instructions.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, STOP.
- IDLE: moves to FETCH when `start_i`=1; otherwise stays.
- FETCH:
  - Latches `icode_i` into an internal icode register.
  - Fault priority is `imem_error_i` > `!instr_valid_i` > icode==0 (halt).
  - On a fault or halt: `stat_o` becomes 3, 4 or 2 respectively; next state is STOP.
  - Otherwise next state is DECODE.
- DECODE → EXEC → MEM: unconditional, one cycle each.
- MEM, memory-class icode (latched icode ∈ {4,5,8,9,A,B}):
  - `mem_req_o` is high for the whole state.
  - The block stays in MEM until `mem_ready_i`=1.
  - If `dmem_error_i`=1 in that same cycle: `stat_o` becomes 3 and next state is STOP, skipping WB and PCUPD.
  - Otherwise next state is WB.
- MEM, any other icode: one cycle, `mem_req_o`=0, next state WB. `mem_ready_i` and `dmem_error_i` are ignored.
- WB → PCUPD: unconditional.
- PCUPD: `pc_o` ← `new_pc_i`; `instr_cnt_o` += 1; next state FETCH.
- STOP: terminal until `rst_i`.
  - All enables are 0.
  - `pc_o` holds the faulting or halt address.
  - `start_i` is ignored.
- Stage enables are Moore-decoded from the state: exactly one is high in FETCH through PCUPD, and all are 0 in IDLE and STOP.
  - The `f_en_o` through `pc_en_o` order maps 1:1 to FETCH through PCUPD.
  - `m_en_o` is high in every MEM cycle, including wait cycles.
- `cycle_cnt_o` increments in every cycle where `running_o`=1.
- Both counters wrap modulo 2^CNT_W with no saturation and no flag.
- `stat_o` changes only on entry to STOP. It remains 1 otherwise.
- A halt instruction is not counted as retired.

## Timing
Reset values, with `rst_i` sampled high:
- state = IDLE, `pc_o` = RESET_PC, `stat_o` = 1.
- All enables, `mem_req_o` and `running_o` = 0.
- Both counters = 0.
- The latched icode = 0.

Reset behaviour:
- Reset wins over every other input in the same cycle.
- Reset in any state, including mid-MEM wait or STOP, returns to IDLE on the next edge.
- `mem_req_o` drops in the cycle after reset is sampled.

Latency:
- First FETCH cycle: the cycle after `start_i` is sampled high in IDLE.
- A non-memory instruction takes 6 cycles, FETCH through PCUPD.
- A memory instruction takes 6 + N cycles, where N is the number of MEM cycles with `mem_ready_i`=0.
- `pc_o` changes at the edge ending PCUPD, so the next FETCH sees the new PC.
- `new_pc_i` is sampled only in PCUPD.
- The fetch inputs are sampled only in FETCH.

Simultaneous events:
- `imem_error_i` and `!instr_valid_i` together give ADR.
- `mem_ready_i`=1 in the first MEM cycle means no wait.
- `dmem_error_i`=1 while `mem_ready_i`=0 is ignored.
- Counter wrap in the same cycle as STOP entry: the counter wraps, then freezes.

## Test plan
- Reset, then `start_i`=1 with icode=6 (OPq), valid, `new_pc_i`=2:
  - FETCH follows 1 cycle after start.
  - Enables step one-hot over 6 cycles.
  - `pc_o`=2 at the next FETCH; `instr_cnt_o`=1; `cycle_cnt_o`=6.
- icode=5 (mrmovq) with `mem_ready_i` held low 3 cycles:
  - `mem_req_o` and `m_en_o` stay high for 4 MEM cycles.
  - WB follows; instruction total is 9 cycles.
- icode=0 at PC=0x10:
  - STOP after FETCH, `stat_o`=2, `pc_o`=0x10.
  - `instr_cnt_o` unchanged; all enables 0 for 10+ cycles despite `start_i`=1.
- `imem_error_i`=1 and `instr_valid_i`=0 together → `stat_o`=3.
- `instr_valid_i`=0 alone → `stat_o`=4.
- icode=A (pushq), `mem_ready_i`=1 with `dmem_error_i`=1 → `stat_o`=3, STOP, and no WB or PCUPD cycle.
- `rst_i` asserted on the second MEM wait cycle:
  - IDLE next cycle; `pc_o`=RESET_PC; `stat_o`=1; counters 0; `mem_req_o`=0.
- With CNT_W overridden to 4, run 17 non-halt cycles → `cycle_cnt_o` wraps to 1.

Source files
------------

// File: rtl/seq_mem_if.sv
// Data-memory handshake between the sequencer and data memory.
// The sequencer raises a request; memory answers with ready and an error flag.
interface seq_mem_if;
    logic mem_req_o;
    logic mem_ready_i;
    logic dmem_error_i;

    modport master (
        output mem_req_o,
        input  mem_ready_i,
        input  dmem_error_i
    );

    modport slave (
        input  mem_req_o,
        output mem_ready_i,
        output dmem_error_i
    );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for the SEQ Y86-64 core.
// Owns the PC, steps one-hot stage enables and folds faults into stat.
module seq_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    seq_mem_if.master        mem,
    input  logic [63:0]      new_pc_i,
    output logic [63:0]      pc_o,
    output logic             f_en_o,
    output logic             d_en_o,
    output logic             e_en_o,
    output logic             m_en_o,
    output logic             w_en_o,
    output logic             pc_en_o,
    output logic [2:0]       stat_o,
    output logic             running_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCUPD,
        S_STOP
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      icode_q;
    logic [63:0]     pc_q;
    logic [2:0]      stat_q;
    logic [2:0]      stat_d;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;
    logic            is_mem;

    // Memory-class instructions: rmmovq, mrmovq, call, ret, pushq, popq.
    always_comb begin
        is_mem = 1'b0;
        unique case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
            default:                            is_mem = 1'b0;
        endcase
    end

    // Next-state and stop-status selection.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error_i) begin
                    stat_d  = STAT_ADR;
                    state_d = S_STOP;
                end else if (!instr_valid_i) begin
                    stat_d  = STAT_INS;
                    state_d = S_STOP;
                end else if (icode_i == 4'h0) begin
                    stat_d  = STAT_HLT;
                    state_d = S_STOP;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_MEM;
            S_MEM: begin
                if (!is_mem) begin
                    state_d = S_WB;
                end else if (mem.mem_ready_i) begin
                    if (mem.dmem_error_i) begin
                        stat_d  = STAT_ADR;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB:    state_d = S_PCUPD;
            S_PCUPD: state_d = S_FETCH;
            S_STOP:  state_d = S_STOP;
            default: state_d = S_IDLE;
        endcase
    end

    // Architectural state: sequencer state, PC, latched icode, status, counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            icode_q <= 4'h0;
            stat_q  <= STAT_AOK;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            if (state_q == S_FETCH) icode_q <= icode_i;
            if (state_q == S_PCUPD) begin
                pc_q    <= new_pc_i;
                instr_q <= instr_q + CNT_W'(1);
            end
            if (running_o) cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign running_o     = (state_q != S_IDLE) && (state_q != S_STOP);
    assign f_en_o        = (state_q == S_FETCH);
    assign d_en_o        = (state_q == S_DECODE);
    assign e_en_o        = (state_q == S_EXEC);
    assign m_en_o        = (state_q == S_MEM);
    assign w_en_o        = (state_q == S_WB);
    assign pc_en_o       = (state_q == S_PCUPD);
    assign mem.mem_req_o = (state_q == S_MEM) && is_mem;
    assign pc_o          = pc_q;
    assign stat_o        = stat_q;
    assign cycle_cnt_o   = cycle_q;
    assign instr_cnt_o   = instr_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: fetch-fault table, directed
// multi-cycle sequences, random instruction stream and counter wrap.
module tb_seq_ctrl;

    localparam logic [5:0] EN_0 = 6'b000000;
    localparam logic [5:0] EN_F = 6'b100000;
    localparam logic [5:0] EN_D = 6'b010000;
    localparam logic [5:0] EN_E = 6'b001000;
    localparam logic [5:0] EN_M = 6'b000100;
    localparam logic [5:0] EN_W = 6'b000010;
    localparam logic [5:0] EN_P = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic        valid;
    logic        ierr;
    logic [63:0] new_pc;
    logic [63:0] pc;
    logic        f_en, d_en, e_en, m_en, w_en, pc_en;
    logic [2:0]  stat;
    logic        running;
    logic [31:0] cyc;
    logic [31:0] icnt;
    logic [5:0]  en;

    logic        w_rst;
    logic        w_start;
    logic [63:0] w_pc;
    logic        w_f, w_d, w_e, w_m, w_w, w_p;
    logic [2:0]  w_stat;
    logic        w_run;
    logic [3:0]  w_cyc;
    logic [3:0]  w_icnt;

    int n_cmp = 0;
    int n_bad = 0;

    seq_mem_if m_if ();
    seq_mem_if w_if ();

    always #5 clk = ~clk;

    seq_ctrl u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .icode_i       (icode),
        .instr_valid_i (valid),
        .imem_error_i  (ierr),
        .mem           (m_if.master),
        .new_pc_i      (new_pc),
        .pc_o          (pc),
        .f_en_o        (f_en),
        .d_en_o        (d_en),
        .e_en_o        (e_en),
        .m_en_o        (m_en),
        .w_en_o        (w_en),
        .pc_en_o       (pc_en),
        .stat_o        (stat),
        .running_o     (running),
        .cycle_cnt_o   (cyc),
        .instr_cnt_o   (icnt)
    );

    seq_ctrl #(.RESET_PC(64'h40), .CNT_W(4)) u_wrap (
        .clk_i         (clk),
        .rst_i         (w_rst),
        .start_i       (w_start),
        .icode_i       (4'h6),
        .instr_valid_i (1'b1),
        .imem_error_i  (1'b0),
        .mem           (w_if.master),
        .new_pc_i      (64'h40),
        .pc_o          (w_pc),
        .f_en_o        (w_f),
        .d_en_o        (w_d),
        .e_en_o        (w_e),
        .m_en_o        (w_m),
        .w_en_o        (w_w),
        .pc_en_o       (w_p),
        .stat_o        (w_stat),
        .running_o     (w_run),
        .cycle_cnt_o   (w_cyc),
        .instr_cnt_o   (w_icnt)
    );

    assign en = {f_en, d_en, e_en, m_en, w_en, pc_en};
    assign w_if.mem_ready_i  = 1'b1;
    assign w_if.dmem_error_i = 1'b0;

    typedef struct {
        logic       ierr;
        logic       valid;
        logic [3:0] icode;
        logic [2:0] stat;
        logic [5:0] en;
    } fvec_t;

    fvec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mem_class(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        chk("rst_pc", pc, 64'h0);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_en", 64'(en), 64'(EN_0));
        chk("rst_req", 64'(m_if.mem_req_o), 64'd0);
        chk("rst_run", 64'(running), 64'd0);
        chk("rst_cnt", {cyc, icnt}, 64'd0);
        rst = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_fetch", 64'(en), 64'(EN_F));
    endtask

    // Drive one fetch of a non-faulting instruction and advance to MEM.
    task automatic to_mem(input logic [3:0] ic);
        icode = ic;
        valid = 1'b1;
        ierr  = 1'b0;
        tick();
        icode = 4'h0;
        valid = 1'b0;
        ierr  = 1'b1;
        chk("step_d", 64'(en), 64'(EN_D));
        tick();
        chk("step_e", 64'(en), 64'(EN_E));
        tick();
        chk("step_m", 64'(en), 64'(EN_M));
    endtask

    logic [63:0] m_pc;
    logic [31:0] m_cyc;
    logic [31:0] m_icnt;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'h6, 3'd3, EN_0};
        tbl[1] = '{1'b0, 1'b0, 4'h6, 3'd4, EN_0};
        tbl[2] = '{1'b1, 1'b1, 4'h6, 3'd3, EN_0};
        tbl[3] = '{1'b0, 1'b1, 4'h0, 3'd2, EN_0};
        tbl[4] = '{1'b0, 1'b1, 4'h6, 3'd1, EN_D};
        tbl[5] = '{1'b0, 1'b0, 4'h0, 3'd4, EN_0};

        rst    = 1'b1;
        start  = 1'b0;
        icode  = 4'h0;
        valid  = 1'b0;
        ierr   = 1'b0;
        new_pc = 64'h0;
        m_if.mem_ready_i  = 1'b0;
        m_if.dmem_error_i = 1'b0;
        w_rst   = 1'b1;
        w_start = 1'b0;

        // Fetch-stage fault priority table.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start_run();
            ierr  = tbl[i].ierr;
            valid = tbl[i].valid;
            icode = tbl[i].icode;
            tick();
            chk($sformatf("tbl%0d_stat", i), 64'(stat), 64'(tbl[i].stat));
            chk($sformatf("tbl%0d_en", i), 64'(en), 64'(tbl[i].en));
            chk($sformatf("tbl%0d_pc", i), pc, 64'h0);
        end

        // OPq: six one-hot cycles, non-memory MEM ignores ready/error.
        do_reset();
        m_if.mem_ready_i  = 1'b0;
        m_if.dmem_error_i = 1'b1;
        start_run();
        to_mem(4'h6);
        chk("opq_req", 64'(m_if.mem_req_o), 64'd0);
        new_pc = 64'h2;
        tick();
        chk("opq_wb", 64'(en), 64'(EN_W));
        tick();
        chk("opq_pcupd", 64'(en), 64'(EN_P));
        chk("opq_pc_hold", pc, 64'h0);
        tick();
        chk("opq_fetch", 64'(en), 64'(EN_F));
        chk("opq_pc", pc, 64'h2);
        chk("opq_icnt", 64'(icnt), 64'd1);
        chk("opq_cyc", 64'(cyc), 64'd6);

        // mrmovq with three wait cycles; error while not ready is ignored.
        to_mem(4'h5);
        for (int i = 0; i < 4; i++) begin
            m_if.mem_ready_i  = (i == 3);
            m_if.dmem_error_i = (i != 3);
            chk($sformatf("mr_men%0d", i), 64'(en), 64'(EN_M));
            chk($sformatf("mr_req%0d", i), 64'(m_if.mem_req_o), 64'd1);
            tick();
        end
        m_if.mem_ready_i  = 1'b0;
        m_if.dmem_error_i = 1'b0;
        chk("mr_wb", 64'(en), 64'(EN_W));
        chk("mr_stat", 64'(stat), 64'd1);
        new_pc = 64'h10;
        tick();
        tick();
        chk("mr_fetch", 64'(en), 64'(EN_F));
        chk("mr_pc", pc, 64'h10);
        chk("mr_cyc", 64'(cyc), 64'd15);
        chk("mr_icnt", 64'(icnt), 64'd2);

        // Halt at 0x10: STOP is terminal and ignores start.
        icode = 4'h0;
        valid = 1'b1;
        ierr  = 1'b0;
        tick();
        chk("hlt_stat", 64'(stat), 64'd2);
        chk("hlt_pc", pc, 64'h10);
        chk("hlt_icnt", 64'(icnt), 64'd2);
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            icode = 4'(i);
            tick();
            chk("stop_en", {58'd0, en}, 64'd0);
            chk("stop_run", 64'(running), 64'd0);
        end
        start = 1'b0;
        chk("stop_cyc", 64'(cyc), 64'd16);
        chk("stop_stat", 64'(stat), 64'd2);

        // pushq with a data fault on the ready cycle: straight to STOP.
        do_reset();
        start_run();
        to_mem(4'hA);
        m_if.mem_ready_i  = 1'b1;
        m_if.dmem_error_i = 1'b1;
        chk("push_req", 64'(m_if.mem_req_o), 64'd1);
        tick();
        m_if.mem_ready_i  = 1'b0;
        m_if.dmem_error_i = 1'b0;
        chk("push_stat", 64'(stat), 64'd3);
        chk("push_en", 64'(en), 64'(EN_0));
        tick();
        chk("push_nowb", 64'(en), 64'(EN_0));
        chk("push_icnt", 64'(icnt), 64'd0);
        chk("push_pc", pc, 64'h0);

        // Reset in the second MEM wait cycle.
        do_reset();
        new_pc = 64'h88;
        start_run();
        to_mem(4'h5);
        tick();
        chk("rmw_req", 64'(m_if.mem_req_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmw_en", 64'(en), 64'(EN_0));
        chk("rmw_req0", 64'(m_if.mem_req_o), 64'd0);
        chk("rmw_pc", pc, 64'h0);
        chk("rmw_stat", 64'(stat), 64'd1);
        chk("rmw_cnt", {cyc, icnt}, 64'd0);

        // Random instruction stream against an instruction-level model.
        do_reset();
        start_run();
        m_pc   = 64'h0;
        m_cyc  = 32'd0;
        m_icnt = 32'd0;
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  ic;
            logic [63:0] npc;
            int          waits;
            ic    = 4'($urandom_range(1, 11));
            npc   = {$urandom, $urandom};
            waits = mem_class(ic) ? $urandom_range(0, 3) : 0;
            chk("rnd_fetch", 64'(en), 64'(EN_F));
            chk("rnd_pc", pc, m_pc);
            chk("rnd_cyc", 64'(cyc), 64'(m_cyc));
            chk("rnd_icnt", 64'(icnt), 64'(m_icnt));
            new_pc = ~npc;
            to_mem(ic);
            if (mem_class(ic)) begin
                for (int i = 0; i <= waits; i++) begin
                    m_if.mem_ready_i  = (i == waits);
                    m_if.dmem_error_i = (i == waits) ? 1'b0 : 1'($urandom);
                    chk("rnd_mreq", 64'(m_if.mem_req_o), 64'd1);
                    chk("rnd_men", 64'(en), 64'(EN_M));
                    tick();
                end
            end else begin
                m_if.mem_ready_i  = 1'($urandom);
                m_if.dmem_error_i = 1'($urandom);
                chk("rnd_noreq", 64'(m_if.mem_req_o), 64'd0);
                tick();
            end
            m_if.mem_ready_i  = 1'b0;
            m_if.dmem_error_i = 1'b0;
            chk("rnd_wb", 64'(en), 64'(EN_W));
            tick();
            chk("rnd_pcupd", 64'(en), 64'(EN_P));
            new_pc = npc;
            tick();
            new_pc = 64'h0;
            m_pc   = npc;
            m_icnt = m_icnt + 1;
            m_cyc  = m_cyc + 32'(6 + waits);
        end
        chk("rnd_end_pc", pc, m_pc);
        chk("rnd_end_cyc", 64'(cyc), 64'(m_cyc));
        chk("rnd_end_stat", 64'(stat), 64'd1);

        // Narrow counters wrap: 17 running cycles on a 4-bit counter.
        w_rst = 1'b1;
        tick();
        chk("w_rst_pc", w_pc, 64'h40);
        chk("w_rst_cyc", 64'(w_cyc), 64'd0);
        w_rst   = 1'b0;
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("w_cyc", 64'(w_cyc), 64'd1);
        chk("w_icnt", 64'(w_icnt), 64'd2);
        chk("w_run", 64'(w_run), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
